// File: rtl/griffin_pkg.sv
// Shared definitions for the griffin sponge.
// Holds the field parameters, the sponge geometry (rate 2, capacity 1) and the
// sponge FSM state encoding.
package griffin_pkg;

    localparam int unsigned N_BITS = 254;
    localparam logic [N_BITS-1:0] PRIME_MODULUS =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
    localparam int unsigned STATE_SIZE = 3;
    localparam int unsigned RATE = 2;
    localparam int unsigned CAPACITY = 1;

    typedef enum logic [2:0] {
        StIdle,
        StAbsorb,
        StPad,
        StPermute,
        StWait,
        StSqueeze
    } sponge_state_e;

endpackage

// File: rtl/mod_add.sv
// Combinational modular adder: sum = (a + b) mod p.
// Works for any a + b < 2p, using one conditional subtraction at N_BITS+1 width.
// Ports:
//   a, b  addends (N_BITS)
//   sum   reduced sum (N_BITS)
module mod_add #(
    parameter int unsigned N_BITS = griffin_pkg::N_BITS,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = griffin_pkg::PRIME_MODULUS
) (
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic [N_BITS-1:0] sum
);

    logic [N_BITS:0] raw;
    logic [N_BITS:0] p_ext;

    assign p_ext = {1'b0, PRIME_MODULUS};
    assign raw   = {1'b0, a} + {1'b0, b};
    assign sum   = N_BITS'((raw >= p_ext) ? (raw - p_ext) : raw);

endmodule

// File: rtl/griffin_sponge.sv
// Griffin sponge (rate 2, capacity 1) around an external permutation.
// Absorbs field elements into lanes 0/1, pads with [1,0] after the last element
// (lane 1 += 1 when one slot is left, otherwise a whole extra block with lane 0 += 1),
// hands each block to the permutation and returns lane 0 of the final state.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   in_valid/in_ready     message element handshake; in_data, in_last
//   perm_start            one-cycle start pulse to the permutation
//   perm_state_out        state handed to the permutation (lane i at [i*N_BITS +: N_BITS])
//   perm_state_in         permuted state, same packing; perm_done marks it valid
//   digest_valid/ready    digest handshake; digest = lane 0 of final state
module griffin_sponge #(
    parameter int unsigned N_BITS = griffin_pkg::N_BITS,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = griffin_pkg::PRIME_MODULUS,
    parameter int unsigned STATE_SIZE = griffin_pkg::STATE_SIZE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_BITS-1:0]            in_data,
    input  logic                         in_last,
    output logic                         perm_start,
    output logic [N_BITS*STATE_SIZE-1:0] perm_state_out,
    input  logic [N_BITS*STATE_SIZE-1:0] perm_state_in,
    input  logic                         perm_done,
    output logic                         digest_valid,
    input  logic                         digest_ready,
    output logic [N_BITS-1:0]            digest
);

    import griffin_pkg::*;

    localparam logic [N_BITS-1:0] ONE = N_BITS'(1);

    sponge_state_e     state_q;
    logic [N_BITS-1:0] lane_q [3];
    logic              idx_q;      // rate index; "reaching 2" is an absorb while idx_q = 1
    logic              final_q;    // the block in flight is the last one
    logic              pad_q;      // a padding-only block follows the block in flight

    logic [N_BITS-1:0] pin0, pin1, pin2;
    logic [N_BITS-1:0] in_red, abs_a, abs_sum, inc_a, inc_sum;

    assign pin0 = perm_state_in[0*N_BITS +: N_BITS];
    assign pin1 = perm_state_in[1*N_BITS +: N_BITS];
    assign pin2 = perm_state_in[2*N_BITS +: N_BITS];

    // Gated by reset so the port reads 0 while reset is held.
    assign in_ready = reset && (state_q == StIdle || state_q == StAbsorb);

    assign abs_a = idx_q ? lane_q[1] : lane_q[0];
    // The +1 is applied to lane 1 when padding inside the last block, or to the
    // freshly permuted lane 0 when a padding-only block follows.
    assign inc_a = (state_q == StWait) ? pin0 : lane_q[1];

    mod_add #(.N_BITS(N_BITS), .PRIME_MODULUS(PRIME_MODULUS)) u_reduce (
        .a   (in_data),
        .b   ('0),
        .sum (in_red)
    );

    mod_add #(.N_BITS(N_BITS), .PRIME_MODULUS(PRIME_MODULUS)) u_absorb (
        .a   (abs_a),
        .b   (in_red),
        .sum (abs_sum)
    );

    mod_add #(.N_BITS(N_BITS), .PRIME_MODULUS(PRIME_MODULUS)) u_pad (
        .a   (inc_a),
        .b   (ONE),
        .sum (inc_sum)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            lane_q[0]      <= '0;
            lane_q[1]      <= '0;
            lane_q[2]      <= '0;
            idx_q          <= 1'b0;
            final_q        <= 1'b0;
            pad_q          <= 1'b0;
            perm_start     <= 1'b0;
            perm_state_out <= '0;
            digest_valid   <= 1'b0;
            digest         <= '0;
        end else begin
            perm_start <= 1'b0;
            unique case (state_q)
                StIdle, StAbsorb: begin
                    if (in_valid) begin
                        if (!idx_q) begin
                            lane_q[0] <= abs_sum;
                            if (in_last) begin
                                lane_q[1]      <= inc_sum;
                                final_q        <= 1'b1;
                                state_q        <= StPermute;
                                perm_start     <= 1'b1;
                                perm_state_out <= {lane_q[2], inc_sum, abs_sum};
                            end else begin
                                idx_q   <= 1'b1;
                                state_q <= StAbsorb;
                            end
                        end else begin
                            lane_q[1] <= abs_sum;
                            idx_q     <= 1'b0;
                            if (in_last) begin
                                state_q <= StPad;
                            end else begin
                                state_q        <= StPermute;
                                perm_start     <= 1'b1;
                                perm_state_out <= {lane_q[2], abs_sum, lane_q[0]};
                            end
                        end
                    end
                end
                StPad: begin
                    pad_q          <= 1'b1;
                    state_q        <= StPermute;
                    perm_start     <= 1'b1;
                    perm_state_out <= {lane_q[2], lane_q[1], lane_q[0]};
                end
                StPermute: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (perm_done) begin
                        lane_q[0] <= pin0;
                        lane_q[1] <= pin1;
                        lane_q[2] <= pin2;
                        if (final_q) begin
                            state_q      <= StSqueeze;
                            digest_valid <= 1'b1;
                            digest       <= pin0;
                        end else if (pad_q) begin
                            lane_q[0]      <= inc_sum;
                            pad_q          <= 1'b0;
                            final_q        <= 1'b1;
                            state_q        <= StPermute;
                            perm_start     <= 1'b1;
                            perm_state_out <= {pin2, pin1, inc_sum};
                        end else begin
                            state_q <= StAbsorb;
                        end
                    end
                end
                StSqueeze: begin
                    if (digest_ready) begin
                        digest_valid <= 1'b0;
                        digest       <= '0;
                        state_q      <= StIdle;
                        lane_q[0]    <= '0;
                        lane_q[1]    <= '0;
                        lane_q[2]    <= '0;
                        idx_q        <= 1'b0;
                        final_q      <= 1'b0;
                        pad_q        <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/griffin_sponge.md
GRIFFIN_SPONGE -- requirements
Module: griffin_sponge

Interface
REQ-001 Parameter N_BITS, default 254, field element width.
REQ-002 Parameter PRIME_MODULUS, default 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001, field prime p.
REQ-003 Parameter STATE_SIZE, default 3, permutation width; RATE = 2, CAPACITY = 1, both fixed.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-low: asserted at 0, released at 1.
REQ-006 in_valid  input  1  message element offered.
REQ-007 in_ready  output  1  sponge accepts element this cycle.
REQ-008 in_data  input  N_BITS  message field element.
REQ-009 in_last  input  1  element is the final one of its message.
REQ-010 perm_start  output  1  one-cycle enable pulse to the downstream griffin permutation.
REQ-011 perm_state_out  output  N_BITS x STATE_SIZE  state presented to the permutation.
REQ-012 perm_state_in  input  N_BITS x STATE_SIZE  permuted state returned.
REQ-013 perm_done  input  1  permutation result valid this cycle (single-cycle pulse).
REQ-014 digest_valid  output  1  digest available.
REQ-015 digest_ready  input  1  consumer takes digest.
REQ-016 digest  output  N_BITS  hash output, lane 0 of final state.

Function
REQ-017 Element transfer occurs on a rising edge with in_valid && in_ready; digest transfer on digest_valid && digest_ready.
REQ-018 FSM states: IDLE, ABSORB, PAD, PERMUTE, WAIT, SQUEEZE.
REQ-019 IDLE: state lanes = 0, rate index = 0, in_ready = 1; an accepted element enters ABSORB handling in the same edge.
REQ-020 Absorb: lane[idx] <= mod_add(lane[idx], in_data); idx increments; in_ready = 1 only in IDLE/ABSORB.
REQ-021 in_data >= p is reduced by one conditional subtraction of p before addition; mod_add(a,b) = a+b, minus p if result >= p, computed at N_BITS+1 width.
REQ-022 When idx reaches 2 without in_last: go to PERMUTE, idx <= 0.
REQ-023 On in_last: if idx after absorb is 1, lane[1] <= lane[1]+1 mod p in the same edge, then PERMUTE with a final flag set; if idx after absorb is 2, go to PAD.
REQ-024 PAD: permute the full block first; the following block absorbs [1,0] (lane 0 += 1) without input, then final permutation.
REQ-025 PERMUTE: perm_start = 1 for exactly one cycle, then WAIT; perm_state_out is registered and held constant from PERMUTE entry until perm_done.
REQ-026 WAIT: in_ready = 0; on perm_done, lanes <= perm_state_in; go to SQUEEZE if final, PERMUTE if pad block pending, else ABSORB.
REQ-027 SQUEEZE: digest_valid = 1, digest = lane 0, both held stable until accepted; on accept, go to IDLE and clear lanes.
REQ-028 perm_done outside WAIT is ignored; digest_ready outside SQUEEZE is ignored.
REQ-029 Latency: one cycle per absorbed element plus one PERMUTE cycle plus permutation latency per block; digest_valid rises the cycle after the final perm_done.
REQ-030 Capacity lane 2 is never written by absorption.

Reset
REQ-031 While reset = 0: FSM = IDLE, lanes = 0, idx = 0, flags = 0, in_ready = 0, perm_start = 0, perm_state_out = 0, digest_valid = 0, digest = 0.
REQ-032 Reset mid-operation abandons the message; in_ready = 1 the first cycle after release; a late perm_done is ignored.

Structure
REQ-033 Shared package griffin_pkg holds N_BITS, PRIME_MODULUS, STATE_SIZE, RATE, and the sponge FSM state enum.
REQ-034 One combinational sub-module mod_add (inputs a, b, output sum mod p) is instantiated for lane updates and padding.

Verification
REQ-035 Single element 5 with last -> perm_state_out = {5,1,0}, one perm_start pulse; stub returns {9,8,7} -> digest = 9.
REQ-036 Elements 3, 4(last) -> first permutation {3,4,0}; stub {10,20,30} -> second permutation {11,20,30}; digest = stub lane 0.
REQ-037 in_data = p+2 into zero lane -> lane = 2; lane p-1 plus 3 -> lane = 2.
REQ-038 digest_ready held 0 for 10 cycles -> digest_valid and digest stable, in_ready = 0 throughout; accept -> IDLE next cycle.
REQ-039 reset = 0 asserted in WAIT, perm_done pulses after release -> no state change, all outputs zero, in_ready = 1.
REQ-040 in_valid held 1 during WAIT -> no element consumed; perm_start never high for two consecutive cycles.
